serial_receiver: RTL and testbench
==================================

# serial_receiver

Deserializer at the far end of the one-bit serial link, downstream of the serial transmitter. It samples `serial_in` once per `clk`, detects the start bit, and shifts in `DATA_BITS` data bits LSB first. It then checks the even-parity bit and presents the word with a one-cycle valid strobe and an error flag. It also keeps a saturating count of parity-failed frames for the status logic.

## Interface
- `DATA_BITS`, 7, data bits per frame
- `ERR_CNT_W`, 8, width of the parity-error counter
- `clk`  in  1  clock; all sampling on posedge
- `rstn`  in  1  reset, asynchronous, active-low
- `serial_in`  in  1  serial line; idle high
- `err_clr`  in  1  synchronous clear of `err_count`
- `data_out`  out  DATA_BITS  last received word; held until next frame completes
- `valid`  out  1  one-cycle strobe: `data_out` and `parity_err` updated
- `parity_err`  out  1  parity result of last frame; held with `data_out`
- `busy`  out  1  high while in DATA or PARITY
- `err_count`  out  ERR_CNT_W  number of frames with parity error; saturating

## Operation
- Frame on line, one bit per clock: start `0`, `d[0]..d[DATA_BITS-1]`, parity `p = ^d`, then idle `1`. There is no mandatory stop bit, so a new start bit can directly follow `p`.
- FSM states are IDLE, DATA and PARITY. A bit counter `cnt` of width `$clog2(DATA_BITS)` and a shift register `sh[DATA_BITS-1:0]` support them.
- IDLE: if the sampled `serial_in == 0`, go to DATA with `cnt <= 0`. Otherwise stay in IDLE.
- DATA: `sh[cnt] <= serial_in`. If `cnt == DATA_BITS-1`, go to PARITY. Otherwise `cnt <= cnt+1`.
- PARITY: at this edge:
  - `data_out <= sh`
  - `parity_err <= ^sh ^ serial_in`
  - `valid <= 1`
  - go to IDLE
- `valid` is cleared on every other edge, so it is exactly one cycle wide.
- `busy` is high in DATA and PARITY, registered with state.
- `err_count`:
  - If `err_clr` is high, it becomes 0. Clear wins over a simultaneous increment.
  - Otherwise it increments at the PARITY edge when the computed error is 1.
  - It holds at all-ones and does not wrap.
- A line stuck low is treated as back-to-back frames of all-zero data with parity 0; no error results.
- Undefined state encodings return to IDLE.

## Timing
- Reset values: `data_out=0`, `valid=0`, `parity_err=0`, `busy=0`, `err_count=0`, FSM in IDLE, `cnt=0`, `sh=0`.
- Reset mid-frame aborts the frame immediately. No `valid` is produced and the partial word is discarded.
- Edge numbering, with the start bit sampled at edge T:
  - data bits sampled at T+1..T+DATA_BITS
  - parity sampled at T+DATA_BITS+1
  - `valid` is high in the cycle after that edge
- For DATA_BITS=7 the frame takes 9 edges, and a start bit can be sampled at T+9.
- `busy` rises after edge T and falls after edge T+DATA_BITS+1.
- `data_out` and `parity_err` change only at the PARITY edge, and are stable while `valid` is high and after it.

## Configuration
- `RX_SYNC_EN`:
  - Defined: `serial_in` passes through a two-flop synchronizer, both flops reset to 1, before the FSM. All receive timing shifts by +2 edges.
  - Undefined: the FSM samples `serial_in` directly; this is for a same-clock link with the transmitter.
- Both builds produce the same output sequence apart from that 2-cycle offset.

## Test plan
- Idle line high for 20 cycles -> `busy=0`, `valid` never asserted, all outputs at reset values.
- Frame for 7'h55 (line 0,1,0,1,0,1,0,1,0) -> after 9th sample: `valid=1` for one cycle, `data_out=7'h55`, `parity_err=0`, `err_count=0`.
- Frame for 7'h7F with parity 0 (correct parity is 1) -> `data_out=7'h7F`, `parity_err=1`, `err_count=1`. A following correct 7'h7F frame (parity 1) -> `parity_err=0`, `err_count` stays 1.
- Back-to-back 7'h12 (parity 0) then 7'h6C (parity 0) with no idle bit between -> two `valid` pulses 9 cycles apart, with data 7'h12 then 7'h6C, both error-free.
- `rstn` low during data bit 4 of a frame, released, then a frame 7'h01 (parity 1) -> no `valid` for the aborted frame; next `valid` has `data_out=7'h01`.
- ERR_CNT_W=2: five bad-parity frames -> `err_count=3` (saturates). Then `err_clr` pulsed in the same cycle as a sixth bad frame's PARITY edge -> `err_count=0`.

Source files
------------

// File: rtl/serial_receiver.sv
// serial_receiver: one-bit serial link deserializer.
// Frame: start 0, DATA_BITS data bits LSB first, even parity bit p = ^d.
// Presents each word with a one-cycle valid strobe and parity error flag,
// and keeps a saturating count of parity-failed frames.
// Optional build macro RX_SYNC_EN: adds a two-flop input synchronizer
// (reset to idle-high), shifting all receive timing by two edges.
module serial_receiver #(
  parameter int unsigned DATA_BITS = 7,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [DATA_BITS-1:0] r_sh;
  logic                 w_rx;
  logic                 w_perr;

`ifdef RX_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;
`else
  assign w_rx = serial_in;
`endif

  // Received parity bit against the assembled word: 1 means even parity violated
  assign w_perr = (^r_sh) ^ w_rx;

  // Receive FSM with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_DATA: begin
          r_sh[r_cnt] <= w_rx;
          if (r_cnt == LAST_BIT) begin
            r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          data_out   <= r_sh;
          parity_err <= w_perr;
          valid      <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Saturating parity-error counter; clear has priority over increment
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (r_state == S_PARITY && w_perr && err_count != '1) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Testbench for serial_receiver: two instances (ERR_CNT_W 8 and 2) share one line.
// Expected words are queued when a frame is driven and popped on each valid.
module tb_serial_receiver;

  logic       clk;
  logic       rstn;
  logic       serial_in;
  logic       err_clr;
  logic [6:0] data_out8, data_out2;
  logic       valid8, valid2;
  logic       perr8, perr2;
  logic       busy8, busy2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  serial_receiver #(.DATA_BITS(7), .ERR_CNT_W(8)) u_dut8 (
    .clk(clk), .rstn(rstn), .serial_in(serial_in), .err_clr(err_clr),
    .data_out(data_out8), .valid(valid8), .parity_err(perr8),
    .busy(busy8), .err_count(cnt8)
  );

  serial_receiver #(.DATA_BITS(7), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .serial_in(serial_in), .err_clr(err_clr),
    .data_out(data_out2), .valid(valid2), .parity_err(perr2),
    .busy(busy2), .err_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] d;
    logic       e;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_valid = 0;
  int   n_push  = 0;
  int   cyc     = 0;
  int   vt[64];
  logic prev_valid = 1'b0;
  logic [7:0] m_c8 = '0;
  logic [1:0] m_c2 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (valid8) begin
      check("valid_width", prev_valid, 1'b0);
      check("valid_w2", valid2, 1'b1);
      if (n_valid < 64) vt[n_valid] = cyc;
      n_valid++;
      if (q.size() == 0) begin
        check("spurious_valid", valid8, 1'b0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data8", data_out8, e.d);
        check("data2", data_out2, e.d);
        check("perr8", perr8, e.e);
        check("perr2", perr2, e.e);
        check("cnt8", cnt8, e.c8);
        check("cnt2", cnt2, e.c2);
      end
    end
    prev_valid = valid8;
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; with clr set, err_clr covers the PARITY edge in either build
  task automatic send_frame(input logic [6:0] d, input logic p, input logic clr);
    exp_t e;
    logic err;
    err = (^d) ^ p;
    if (clr) begin
      m_c8 = '0;
      m_c2 = '0;
    end else if (err) begin
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c2 != 2'h3)  m_c2 = m_c2 + 2'd1;
    end
    e.d = d; e.e = err; e.c8 = m_c8; e.c2 = m_c2;
    q.push_back(e);
    n_push++;
    send_bit(1'b0);
    for (int unsigned i = 0; i < 7; i++) begin
      send_bit(d[i]);
      if (i == 2) begin
        check("busy_mid8", busy8, 1'b1);
        check("busy_mid2", busy2, 1'b1);
      end
    end
    err_clr = clr;
    send_bit(p);
    if (clr) begin
      send_bit(1'b1);
      send_bit(1'b1);
      err_clr = 1'b0;
    end
  endtask

  task automatic drain();
    serial_in = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_idle", busy8, 1'b0);
  endtask

  initial begin
    int idx;
    rstn = 1'b0;
    serial_in = 1'b1;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Idle line
    repeat (20) send_bit(1'b1);
    check("idle_busy", busy8, 1'b0);
    check("idle_valid", valid8, 1'b0);
    check("idle_nvalid", n_valid, 0);
    check("idle_data", data_out8, 7'h00);
    check("idle_perr", perr8, 1'b0);
    check("idle_cnt8", cnt8, 8'h00);
    check("idle_cnt2", cnt2, 2'h0);

    // Good and bad parity frames
    send_frame(7'h55, 1'b0, 1'b0);
    drain();
    send_frame(7'h7F, 1'b0, 1'b0);
    drain();
    send_frame(7'h7F, 1'b1, 1'b0);
    drain();

    // Back-to-back frames, no idle bit between
    idx = n_valid;
    send_frame(7'h12, 1'b0, 1'b0);
    send_frame(7'h6C, 1'b0, 1'b0);
    drain();
    check("b2b_gap", vt[idx+1] - vt[idx], 9);

    // Reset during data bit 4 aborts the frame
    send_bit(1'b0);
    for (int unsigned i = 0; i < 4; i++) send_bit(1'b1);
    serial_in = 1'b0;
    #2;
    rstn = 1'b0;
    m_c8 = '0;
    m_c2 = '0;
    #1;
    check("rst_busy", busy8, 1'b0);
    serial_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_data", data_out8, 7'h00);
    check("rst_cnt8", cnt8, 8'h00);
    repeat (3) send_bit(1'b1);
    send_frame(7'h01, 1'b1, 1'b0);
    drain();

    // Saturation of the narrow counter, then clear racing an increment
    for (int i = 0; i < 5; i++) begin
      send_frame(7'h7F, 1'b0, 1'b0);
      drain();
    end
    check("sat_cnt2", cnt2, 2'h3);
    check("sat_cnt8", cnt8, 8'd5);
    send_frame(7'h7F, 1'b0, 1'b1);
    drain();
    check("clr_cnt8", cnt8, 8'h00);

    check("valid_count", n_valid, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d expected 0 pending", q.size());
    $fatal(1, "timeout");
  end

endmodule
